// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback arbiter and its completion buffer.
package wb_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       wdata;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding long-latency completions until a write slot frees up.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  wb_entry_t push_data_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    wb_entry_t   mem_q [FIFO_DEPTH];
    logic        do_push, do_pop;

    // Extra MSB distinguishes full from empty when the indices coincide.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port arbiter: pipeline first, then buffered completions, then
// direct bypass of a completion; also tracks registers awaiting long-latency results.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipeline_en,
    input  logic                  pipe_wen,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]       pipe_wdata,
    input  logic                  mc_issue,
    input  logic [REG_ADDR_W-1:0] mc_issue_rd,
    input  logic                  mc_valid,
    output logic                  mc_ready,
    input  logic [REG_ADDR_W-1:0] mc_rd,
    input  logic [XLEN-1:0]       mc_wdata,
    output logic                  rf_wen,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]       rf_wdata,
    output logic [NUM_REGS-1:0]   pending,
    output logic                  busy
);
    wb_entry_t           head, push_entry;
    logic                full, empty;
    logic                pipe_sel, fifo_sel, byp_sel, mc_accept, push;
    logic [NUM_REGS-1:0] pending_q, pending_d;

    // mc_ready depends only on occupancy, keeping pipeline_en off the handshake path.
    assign mc_ready  = !full;
    assign mc_accept = mc_valid && mc_ready && (mc_rd != '0);

    assign pipe_sel = pipeline_en && pipe_wen && (pipe_rd != '0);
    assign fifo_sel = pipeline_en && !pipe_sel && !empty;
    assign byp_sel  = pipeline_en && !pipe_sel && empty && mc_accept;
    assign push     = mc_accept && !byp_sel;

    assign push_entry = '{rd: mc_rd, wdata: mc_wdata};

    wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (fifo_sel),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty)
    );

    always_comb begin
        rf_wen   = 1'b0;
        rf_rd    = '0;
        rf_wdata = '0;
        if (pipe_sel) begin
            rf_wen   = 1'b1;
            rf_rd    = pipe_rd;
            rf_wdata = pipe_wdata;
        end else if (fifo_sel) begin
            rf_wen   = 1'b1;
            rf_rd    = head.rd;
            rf_wdata = head.wdata;
        end else if (byp_sel) begin
            rf_wen   = 1'b1;
            rf_rd    = mc_rd;
            rf_wdata = mc_wdata;
        end
    end

    // Set is applied after clears so a same-cycle issue to the retiring register wins.
    always_comb begin
        pending_d = pending_q;
        if (fifo_sel) pending_d[head.rd] = 1'b0;
        if (byp_sel)  pending_d[mc_rd]   = 1'b0;
        if (mc_issue && (mc_issue_rd != '0)) pending_d[mc_issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    assign pending = pending_q;
    assign busy    = !empty;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: pipeline priority, bypass, buffering, stall, scoreboard, reset.
module tb_wb_arbiter;
    import wb_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  pipeline_en, pipe_wen, mc_issue, mc_valid;
    logic [REG_ADDR_W-1:0] pipe_rd, mc_issue_rd, mc_rd;
    logic [XLEN-1:0]       pipe_wdata, mc_wdata;
    logic                  mc_ready, rf_wen, busy;
    logic [REG_ADDR_W-1:0] rf_rd;
    logic [XLEN-1:0]       rf_wdata;
    logic [NUM_REGS-1:0]   pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipeline_en (pipeline_en),
        .pipe_wen    (pipe_wen),
        .pipe_rd     (pipe_rd),
        .pipe_wdata  (pipe_wdata),
        .mc_issue    (mc_issue),
        .mc_issue_rd (mc_issue_rd),
        .mc_valid    (mc_valid),
        .mc_ready    (mc_ready),
        .mc_rd       (mc_rd),
        .mc_wdata    (mc_wdata),
        .rf_wen      (rf_wen),
        .rf_rd       (rf_rd),
        .rf_wdata    (rf_wdata),
        .pending     (pending),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; combinational checks follow #1 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_check(input string tag, input logic wen, input logic [REG_ADDR_W-1:0] rd,
                            input logic [XLEN-1:0] wd);
        check({tag, ".wen"}, rf_wen, wen);
        check({tag, ".rd"}, rf_rd, rd);
        check({tag, ".wdata"}, rf_wdata, wd);
    endtask

    initial begin
        rst_n = 1'b0;
        pipeline_en = 0; pipe_wen = 0; pipe_rd = 0; pipe_wdata = 0;
        mc_issue = 0; mc_issue_rd = 0; mc_valid = 0; mc_rd = 0; mc_wdata = 0;
        #2;
        check("rst.busy", busy, 0);
        check("rst.mc_ready", mc_ready, 1);
        check("rst.rf_wen", rf_wen, 0);
        check("rst.pending", pending, 0);
        #1 rst_n = 1'b1;
        tick();

        // Pipeline only
        pipeline_en = 1; pipe_wen = 1; pipe_rd = 5; pipe_wdata = 32'hDEADBEEF;
        #1 rf_check("pipe", 1, 5, 32'hDEADBEEF);
        pipe_rd = 0;
        #1 rf_check("pipe_rd0", 0, 0, 0);
        tick();
        pipe_wen = 0;

        // Bypass
        mc_issue = 1; mc_issue_rd = 7;
        tick();
        mc_issue = 0;
        check("byp.pending_set", pending, 32'h80);
        mc_valid = 1; mc_rd = 7; mc_wdata = 32'h12;
        #1 rf_check("byp", 1, 7, 32'h12);
        check("byp.ready", mc_ready, 1);
        tick();
        mc_valid = 0;
        check("byp.pending_clr", pending, 0);
        check("byp.no_push", busy, 0);

        // Contention: pipe owns 4 slots while 8, 9, 10 arrive
        pipe_wen = 1; pipe_rd = 3; pipe_wdata = 32'h33;
        mc_valid = 1; mc_rd = 8; mc_wdata = 32'h80;
        #1 rf_check("cont.a", 1, 3, 32'h33);
        tick();
        check("cont.busy", busy, 1);
        mc_rd = 9; mc_wdata = 32'h90;
        #1 check("cont.b_ready", mc_ready, 1);
        tick();
        mc_rd = 10; mc_wdata = 32'hA0;
        #1 check("cont.c_ready", mc_ready, 0);
        rf_check("cont.c", 1, 3, 32'h33);
        tick();
        #1 check("cont.d_ready", mc_ready, 0);
        tick();
        pipe_wen = 0;
        #1 rf_check("cont.e", 1, 8, 32'h80);
        check("cont.e_ready", mc_ready, 0);
        tick();
        #1 rf_check("cont.f", 1, 9, 32'h90);
        check("cont.f_ready", mc_ready, 1);
        tick();
        mc_valid = 0;
        #1 rf_check("cont.g", 1, 10, 32'hA0);
        tick();
        check("cont.idle", busy, 0);

        // Stall with two buffered entries
        pipeline_en = 0;
        mc_valid = 1; mc_rd = 11; mc_wdata = 32'hB1;
        #1 check("stall.wen0", rf_wen, 0);
        tick();
        mc_rd = 12; mc_wdata = 32'hC2;
        tick();
        mc_valid = 0;
        tick();
        tick();
        check("stall.full", mc_ready, 0);
        check("stall.busy", busy, 1);
        rf_check("stall", 0, 0, 0);
        pipeline_en = 1;
        #1 rf_check("drain.1", 1, 11, 32'hB1);
        tick();
        #1 rf_check("drain.2", 1, 12, 32'hC2);
        tick();
        check("drain.empty", busy, 0);

        // Scoreboard edges
        mc_issue = 1; mc_issue_rd = 4;
        tick();
        mc_issue = 0;
        check("sb.set4", pending, 32'h10);
        pipeline_en = 0;
        mc_valid = 1; mc_rd = 4; mc_wdata = 32'h44;
        tick();
        mc_valid = 0;
        pipeline_en = 1; mc_issue = 1; mc_issue_rd = 4;
        #1 rf_check("sb.pop4", 1, 4, 32'h44);
        tick();
        mc_issue = 0;
        check("sb.set_wins", pending, 32'h10);
        mc_issue = 1; mc_issue_rd = 0;
        tick();
        mc_issue = 0;
        check("sb.rd0", pending, 32'h10);
        pipe_wen = 1; pipe_rd = 4; pipe_wdata = 32'h55;
        tick();
        pipe_wen = 0;
        check("sb.pipe_no_clr", pending, 32'h10);

        // Reset mid-operation
        mc_issue = 1; mc_issue_rd = 9;
        tick();
        mc_issue = 0;
        check("rm.pend9", pending, 32'h210);
        pipeline_en = 0;
        mc_valid = 1; mc_rd = 1; mc_wdata = 32'h1;
        tick();
        mc_rd = 2; mc_wdata = 32'h2;
        tick();
        mc_valid = 0;
        check("rm.full", mc_ready, 0);
        pipeline_en = 1;
        rst_n = 0;
        #1;
        check("rm.busy", busy, 0);
        check("rm.pending", pending, 0);
        check("rm.ready", mc_ready, 1);
        check("rm.rf_wen", rf_wen, 0);
        #1 rst_n = 1;
        tick();
        check("rm.after", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
